// File: rtl/ex_core_dmem_rsp.sv
`default_nettype none
// ============================================================================
// ex_core_dmem_rsp : wait-stated byte/half/word data-memory responder
// Revision 1.0
// ============================================================================
module ex_core_dmem_rsp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqAddr,
    input  logic        ReqWrEn,
    input  logic [2:0]  ReqFunct3,
    input  logic [31:0] ReqWrData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspData,
    output logic        RspErr
);

    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              exec;
    logic [ADDR_W-1:0] ex_addr;
    logic              ex_wr;
    logic [2:0]        ex_f3;
    logic [31:0]       ex_wdata;
    logic              ex_err;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       ld_data;
    logic [31:0]       rsp_data_nxt;
    logic [3:0]        wr_be;
    logic [31:0]       wr_lanes;
    logic              do_write;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^ReqAddr[31:ADDR_W];
    assign accept         = ReqValid && ReqReady;

    // With zero latency the access runs on the accept edge, so it decodes the live request.
    assign exec     = (state == S_IDLE && accept && LATENCY == 0) || (state == S_WAIT && cnt == 4'd0);
    assign ex_addr  = (state == S_IDLE) ? ReqAddr[ADDR_W-1:0] : addr_q;
    assign ex_wr    = (state == S_IDLE) ? ReqWrEn : wr_q;
    assign ex_f3    = (state == S_IDLE) ? ReqFunct3 : f3_q;
    assign ex_wdata = (state == S_IDLE) ? ReqWrData : wdata_q;

    always_comb begin
        ex_err = (ex_f3 == 3'b011) || (ex_f3[2:1] == 2'b11) || (ex_wr && ex_f3[2])
              || (ex_f3[1:0] == 2'b01 && ex_addr[0])
              || (ex_f3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);

        rd_word  = mem[ex_addr[ADDR_W-1:2]];
        rd_shift = rd_word >> {ex_addr[1:0], 3'b000};
        case (ex_f3)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase

        case (ex_f3[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << ex_addr[1:0];
                wr_lanes = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                wr_be    = 4'b0011 << ex_addr[1:0];
                wr_lanes = {2{ex_wdata[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = ex_wdata;
            end
        endcase

        do_write     = exec && ex_wr && !ex_err;
        rsp_data_nxt = (ex_err || ex_wr) ? 32'd0 : ld_data;
    end

    always_ff @(posedge Clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[ex_addr[ADDR_W-1:2]][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            f3_q     <= 3'd0;
            wdata_q  <= 32'd0;
            ReqReady <= 1'b0;
            RspValid <= 1'b0;
            RspData  <= 32'd0;
            RspErr   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ReqReady <= 1'b1;
                    if (accept) begin
                        addr_q   <= ReqAddr[ADDR_W-1:0];
                        wr_q     <= ReqWrEn;
                        f3_q     <= ReqFunct3;
                        wdata_q  <= ReqWrData;
                        cnt      <= CNT_INIT;
                        ReqReady <= 1'b0;
                        if (LATENCY == 0) begin
                            state    <= S_RESP;
                            RspValid <= 1'b1;
                            RspData  <= rsp_data_nxt;
                            RspErr   <= ex_err;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= S_RESP;
                        RspValid <= 1'b1;
                        RspData  <= rsp_data_nxt;
                        RspErr   <= ex_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (RspReady) begin
                        state    <= S_IDLE;
                        ReqReady <= 1'b1;
                        RspValid <= 1'b0;
                        RspData  <= 32'd0;
                        RspErr   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_core_dmem_rsp.sv
`default_nettype none
// ============================================================================
// tb_ex_core_dmem_rsp : directed bench for LATENCY=2, 0 and 4 builds
// Revision 1.0
// ============================================================================
module tb_ex_core_dmem_rsp;

    logic        clk;
    logic [2:0]  rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic [2:0]  req_f3;
    logic [31:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_data [3];
    logic [2:0]  rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ex_core_dmem_rsp #(.ADDR_W(10), .LATENCY(2)) u_l2 (
        .Clk(clk), .Rst(rst_n[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
        .ReqAddr(req_addr), .ReqWrEn(req_wr), .ReqFunct3(req_f3), .ReqWrData(req_wdata),
        .RspValid(rsp_valid[0]), .RspReady(rsp_ready[0]), .RspData(rsp_data[0]), .RspErr(rsp_err[0]));

    ex_core_dmem_rsp #(.ADDR_W(10), .LATENCY(0)) u_l0 (
        .Clk(clk), .Rst(rst_n[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
        .ReqAddr(req_addr), .ReqWrEn(req_wr), .ReqFunct3(req_f3), .ReqWrData(req_wdata),
        .RspValid(rsp_valid[1]), .RspReady(rsp_ready[1]), .RspData(rsp_data[1]), .RspErr(rsp_err[1]));

    ex_core_dmem_rsp #(.ADDR_W(10), .LATENCY(4)) u_l4 (
        .Clk(clk), .Rst(rst_n[2]), .ReqValid(req_valid[2]), .ReqReady(req_ready[2]),
        .ReqAddr(req_addr), .ReqWrEn(req_wr), .ReqFunct3(req_f3), .ReqWrData(req_wdata),
        .RspValid(rsp_valid[2]), .RspReady(rsp_ready[2]), .RspData(rsp_data[2]), .RspErr(rsp_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One complete transaction on DUT d with the response accepted immediately.
    task automatic access(input int d, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] data, output logic err,
                          output int lat, output int acc_cyc);
        int n;
        @(negedge clk);
        req_addr     = addr;
        req_wr       = wr;
        req_f3       = f3;
        req_wdata    = wdata;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready[d]}, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        req_valid[d] = 1'b0;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'hA5A5_A5A5;
        req_wr       = ~wr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[d] && lat < 50);
        data = rsp_data[d];
        err  = rsp_err[d];
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc0;
        int          acc1;

        vecs[0]  = '{1'b1, 3'b010, 32'h20,  32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 3'b000, 32'h21,  32'h0000_0080, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 3'b001, 32'h22,  32'h0000_1234, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h21,  32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 32'h21,  32'h0,         32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 3'b001, 32'h22,  32'h0,         32'h0000_1234, 1'b0};
        vecs[6]  = '{1'b0, 3'b010, 32'h20,  32'h0,         32'h1234_8000, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h20,  32'h0,         32'h0000_8000, 1'b0};
        vecs[8]  = '{1'b0, 3'b001, 32'h20,  32'h0,         32'hFFFF_8000, 1'b0};
        vecs[9]  = '{1'b0, 3'b010, 32'h12,  32'h0,         32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 3'b001, 32'h13,  32'h0000_FFFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 3'b010, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{1'b0, 3'b011, 32'h10,  32'h0,         32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 3'b100, 32'h10,  32'h0,         32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 3'b010, 32'h410, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[15] = '{1'b0, 3'b000, 32'h13,  32'h0,         32'hFFFF_FFDE, 1'b0};
        vecs[16] = '{1'b1, 3'b000, 32'h12,  32'hFFFF_FF77, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 3'b010, 32'h10,  32'h0,         32'hDE77_BEEF, 1'b0};
        vecs[18] = '{1'b0, 3'b101, 32'h12,  32'h0,         32'h0000_DE77, 1'b0};
        vecs[19] = '{1'b0, 3'b111, 32'h10,  32'h0,         32'h0000_0000, 1'b1};
        vecs[20] = '{1'b0, 3'b110, 32'h10,  32'h0,         32'h0000_0000, 1'b1};

        rst_n     = 3'b000;
        req_valid = 3'b000;
        rsp_ready = 3'b000;
        req_addr  = 32'd0;
        req_wr    = 1'b0;
        req_f3    = 3'd0;
        req_wdata = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready[0]}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("reset_rsp_data",  rsp_data[0], 32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
        rst_n = 3'b111;
        @(negedge clk);
        chk("post_reset_req_ready", {31'd0, req_ready[0]}, 32'd1);

        // LATENCY=2: word store then load
        access(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, data, err, lat, acc0);
        chk("sw_latency", 32'(lat), 32'd3);
        chk("sw_data", data, 32'd0);
        chk("sw_err", {31'd0, err}, 32'd0);
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, data, err, lat, acc0);
        chk("lw_latency", 32'(lat), 32'd3);
        chk("lw_data", data, 32'hDEAD_BEEF);

        for (int i = 0; i < 21; i++) begin
            access(0, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, data, err, lat, acc0);
            chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Backpressure: hold the response for 5 cycles while a new request waits
        @(negedge clk);
        req_addr     = 32'h10;
        req_wr       = 1'b0;
        req_f3       = 3'b010;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b0;
        chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd1);
        @(posedge clk);
        #1;
        req_addr  = 32'h20;
        req_wr    = 1'b1;
        req_wdata = 32'h0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid[0] && n < 50);
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_c%0d", k), {31'd0, rsp_valid[0]}, 32'd1);
            chk($sformatf("bp_data_c%0d", k), rsp_data[0], 32'hDE77_BEEF);
            chk($sformatf("bp_ready_c%0d", k), {31'd0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("bp_after_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("bp_after_data", rsp_data[0], 32'd0);
        chk("bp_after_req_ready", {31'd0, req_ready[0]}, 32'd1);
        repeat (6) @(negedge clk);
        chk("bp_no_stray_rsp", {31'd0, rsp_valid[0]}, 32'd0);
        access(0, 1'b0, 3'b010, 32'h20, 32'h0, data, err, lat, acc0);
        chk("bp_ignored_store", data, 32'h1234_8000);

        // LATENCY=0 build
        access(1, 1'b1, 3'b010, 32'h8, 32'h1111_1111, data, err, lat, acc0);
        chk("l0_sw_latency", 32'(lat), 32'd1);
        access(1, 1'b0, 3'b010, 32'h8, 32'h0, data, err, lat, acc0);
        access(1, 1'b0, 3'b001, 32'hA, 32'h0, data, err, lat, acc1);
        chk("l0_lh_data", data, 32'h0000_1111);
        chk("l0_lh_latency", 32'(lat), 32'd1);
        chk("l0_throughput", 32'(acc1 - acc0), 32'd2);
        access(1, 1'b0, 3'b001, 32'h9, 32'h0, data, err, lat, acc0);
        chk("l0_misaligned_err", {31'd0, err}, 32'd1);
        chk("l0_misaligned_data", data, 32'd0);

        // LATENCY=4 build: reset while a store waits
        access(2, 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, data, err, lat, acc0);
        chk("l4_sw_latency", 32'(lat), 32'd5);
        @(negedge clk);
        req_addr     = 32'h30;
        req_wr       = 1'b1;
        req_f3       = 3'b010;
        req_wdata    = 32'h55AA_55AA;
        req_valid[2] = 1'b1;
        rsp_ready[2] = 1'b1;
        chk("l4_req_ready", {31'd0, req_ready[2]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        #1;
        chk("l4_reset_rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
        chk("l4_reset_req_ready", {31'd0, req_ready[2]}, 32'd0);
        repeat (6) @(negedge clk);
        rst_n[2] = 1'b1;
        access(2, 1'b0, 3'b010, 32'h30, 32'h0, data, err, lat, acc0);
        chk("l4_dropped_store", data, 32'hCAFE_F00D);
        chk("l4_lw_latency", 32'(lat), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_core_dmem_rsp.md
Name: ex_core_dmem_rsp

Overview:
Data-memory responder for the ex_core load/store path. It accepts single load/store requests from the core over a valid/ready request channel and performs the RISC-V byte, half and word access on an internal 32-bit-wide storage array. After a programmable wait-state delay it returns the load data, or an error, over a valid/ready response channel. It lets the core be exercised against a non-zero-latency memory and defines the contract a future stall-capable core must meet.

Parameters:
ADDR_W, 10, byte-address bits decoded. Array depth is 2^(ADDR_W-2) words. Request address bits above ADDR_W-1 are ignored (aliasing).
LATENCY, 2, wait states between request acceptance and response (0..15).

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-low
ReqValid  in  1  request present
ReqReady  out  1  responder can accept a request
ReqAddr  in  32  byte address
ReqWrEn  in  1  1=store, 0=load
ReqFunct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
ReqWrData  in  32  store data, right-justified
RspValid  out  1  response present
RspReady  in  1  core accepts the response
RspData  out  32  load result, sign- or zero-extended; 0 for stores and errors
RspErr  out  1  misaligned or illegal funct3; access suppressed

Behaviour:
- Reset (Rst=0, asynchronous):
  - FSM goes to IDLE; wait counter cleared.
  - ReqReady=0 during reset, 1 in the first cycle after release.
  - RspValid=0, RspData=0, RspErr=0.
  - Array contents are not reset.
  - A request in flight is dropped. A store not yet committed never writes.
- FSM states: IDLE, WAIT, RESP.
  - ReqReady=1 only in IDLE.
  - RspValid=1 only in RESP.
- IDLE:
  - Accept on ReqValid&ReqReady at edge T. Addr, WrEn, Funct3 and WrData are captured into holding registers.
  - Next state is WAIT when LATENCY>0, RESP when LATENCY=0.
  - The counter loads LATENCY-1 on acceptance.
- WAIT:
  - Counter decrements each cycle.
  - At counter==0 the access executes and the state moves to RESP.
  - The first RspValid cycle is T+1+LATENCY.
- Access execution (single edge, on entry to RESP):
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal funct3: 011, 110, 111; stores with funct3[2]=1.
  - Error case: no array write, RspErr=1, RspData=0.
  - Store: byte enables are 0001<<addr[1:0] (B) or 0011<<addr[1:0] (H) or 1111 (W). Data is replicated across lanes. Only enabled bytes are written. RspData=0, RspErr=0.
  - Load: read word addr[ADDR_W-1:2] and select the lane by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended; W is unchanged.
- RESP:
  - RspValid, RspData and RspErr hold stable until RspReady=1.
  - On RspValid&RspReady the state moves to IDLE, and RspValid, RspData and RspErr clear next cycle.
  - No new request is accepted in the handshake cycle.
  - Peak throughput is one access per LATENCY+2 cycles.
- Ordering and hazards:
  - One outstanding request only.
  - A load after a store to the same address returns the stored data; the store commits before its response.
- Request signals are ignored while ReqReady=0 and need not be held by the core after acceptance.
- The array is single-port with a synchronous write. The read value is registered into the RspData register on RESP entry, so the array needs only one access per request.

Test Plan:
- LATENCY=2, reset release. Store W 0xDEADBEEF @0x10 accepted at cycle 0 -> RspValid at cycle 3, RspData=0, RspErr=0. Then load W @0x10 -> RspData=0xDEADBEEF at acceptance+3.
- Sub-word: store B 0x80 @0x21, store H 0x1234 @0x22 over word 0x00000000. Then:
  - LB @0x21 -> 0xFFFFFF80
  - LBU @0x21 -> 0x00000080
  - LH @0x22 -> 0x00001234
  - LW @0x20 -> 0x12348000
- Misaligned: LW @0x12 -> RspErr=1, RspData=0. SH @0x13 -> RspErr=1 and word 0x10 is unchanged (a following LW still returns 0xDEADBEEF).
- Backpressure: hold RspReady=0 for 5 cycles during a load -> RspValid/RspData stable throughout and ReqReady=0. Assert RspReady -> IDLE next cycle, ReqReady=1.
- LATENCY=0 build: load accepted at cycle 0 -> RspValid at cycle 1. Back-to-back ReqValid with RspReady=1 -> acceptances every 2 cycles.
- Reset mid-operation: store W 0x55AA55AA @0x30 accepted with LATENCY=4, Rst=0 asserted in WAIT at cycle 2 -> RspValid=0 immediately. After release, LW @0x30 returns the pre-store value, not 0x55AA55AA.
